cond_exec_unit: RTL and testbench

Parametrised conditional-execution unit for the pipelined ARM core: holds banked NZCV flag registers, evaluates the 4-bit condition field of the issuing instruction, and tracks an IT-style predication block that supplies per-slot conditions for up to IT_MAX_LEN following instructions. Sits between decode and writeback enables; cond_ex_o gates register, memory and flag writes.

---
 rtl/cond_pkg.sv | 27 ++
 rtl/cond_eval.sv | 43 ++++
 rtl/cond_exec_unit.sv | 146 ++++++++++++++
 tb/tb_cond_exec_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared types and constants for the conditional-execution unit
package cond_pkg;

  // ARM condition field encodings
  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  // bit positions inside the {N,Z,C,V} flag nibble
  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  // flag write-enable masks
  localparam logic [1:0] FLAGW_NZ = 2'b10;
  localparam logic [1:0] FLAGW_CV = 2'b01;

  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational condition-code evaluator (cond, flags) -> (ex, undef)
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       ex,
  output logic       undef
);

  logic n, z, c, v;

  assign n = flags[N_IDX];
  assign z = flags[Z_IDX];
  assign c = flags[C_IDX];
  assign v = flags[V_IDX];

  // decode the condition against the current flags; NV never executes and is flagged undefined
  always_comb begin
    ex    = 1'b0;
    undef = 1'b0;
    case (cond_e'(cond))
      EQ: ex = z;
      NE: ex = ~z;
      CS: ex = c;
      CC: ex = ~c;
      MI: ex = n;
      PL: ex = ~n;
      VS: ex = v;
      VC: ex = ~v;
      HI: ex = c & ~z;
      LS: ex = ~c | z;
      GE: ex = (n == v);
      LT: ex = (n != v);
      GT: ex = ~z & (n == v);
      LE: ex = z | (n != v);
      AL: ex = 1'b1;
      NV: undef = 1'b1;
      default: undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// rtl/cond_exec_unit.sv - banked NZCV flags, condition evaluation and IT predication (IT logic under COND_IT_EN)
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter  int NUM_BANKS  = 2,
  parameter  int IT_MAX_LEN = 4,
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int LW = $clog2(IT_MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid_i,
  input  logic [3:0]            cond_i,
  input  logic [BW-1:0]         bank_sel_i,
  input  logic [1:0]            flag_wr_i,
  input  logic [3:0]            alu_flags_i,
  input  logic                  it_start_i,
  input  logic [3:0]            it_firstcond_i,
  input  logic [LW-1:0]         it_len_i,
  input  logic [IT_MAX_LEN-1:0] it_then_i,
  output logic                  cond_ex_o,
  output logic                  undef_o,
  output logic [3:0]            flags_o,
  output logic                  it_active_o
);

  logic [3:0] banks [NUM_BANKS];
  logic [3:0] sel_flags;
  logic [3:0] eff_cond;
  logic       eval_ex;
  logic       eval_undef;
  logic       it_active;
  logic       it_undef;

  // read mux for the selected bank; an out-of-range select reads as zero
  always_comb begin
    sel_flags = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel_i == BW'(b)) sel_flags = banks[b];
    end
  end

  assign flags_o = sel_flags;

  cond_eval u_eval (
    .cond  (eff_cond),
    .flags (sel_flags),
    .ex    (eval_ex),
    .undef (eval_undef)
  );

  assign cond_ex_o = instr_valid_i & eval_ex;
  assign undef_o   = instr_valid_i & (eval_undef | it_undef);

  // masked flag writeback into the selected bank, only for executed instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) banks[b] <= '0;
    end else if (cond_ex_o) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_sel_i == BW'(b)) begin
          if (|(flag_wr_i & FLAGW_NZ)) banks[b][N_IDX:Z_IDX] <= alu_flags_i[N_IDX:Z_IDX];
          if (|(flag_wr_i & FLAGW_CV)) banks[b][C_IDX:V_IDX] <= alu_flags_i[C_IDX:V_IDX];
        end
      end
    end
  end

`ifdef COND_IT_EN
  localparam logic [LW-1:0] LEN_MAX = LW'(IT_MAX_LEN);

  it_state_e             state_q, state_nxt;
  logic [3:0]            first_q, first_nxt;
  logic [IT_MAX_LEN-1:0] then_q, then_nxt;
  logic [LW-1:0]         rem_q, rem_nxt;
  logic [LW-1:0]         slot_q, slot_nxt;
  logic [IT_MAX_LEN-1:0] then_shift;
  logic                  len_ok;

  assign it_active  = (state_q == IT_ACTIVE);
  assign len_ok     = (it_len_i != '0) && (it_len_i <= LEN_MAX);
  assign then_shift = then_q >> slot_q;
  // a cleared then-bit selects the opposite condition by flipping the LSB
  assign eff_cond   = it_active ? (then_shift[0] ? first_q : {first_q[3:1], ~first_q[0]})
                                : cond_i;
  assign it_undef   = it_start_i & (it_active | ~len_ok);

  // IT block state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IT_IDLE;
      first_q <= '0;
      then_q  <= '0;
      rem_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_nxt;
      first_q <= first_nxt;
      then_q  <= then_nxt;
      rem_q   <= rem_nxt;
      slot_q  <= slot_nxt;
    end
  end

  // IT next state: accept a well-formed executed setup, then consume one slot per valid instruction
  always_comb begin
    state_nxt = state_q;
    first_nxt = first_q;
    then_nxt  = then_q;
    rem_nxt   = rem_q;
    slot_nxt  = slot_q;
    case (state_q)
      IT_IDLE: begin
        if (instr_valid_i && it_start_i && cond_ex_o && len_ok) begin
          state_nxt = IT_ACTIVE;
          first_nxt = it_firstcond_i;
          then_nxt  = it_then_i;
          rem_nxt   = it_len_i;
          slot_nxt  = '0;
        end
      end
      IT_ACTIVE: begin
        if (instr_valid_i) begin
          rem_nxt  = rem_q - LW'(1);
          slot_nxt = slot_q + LW'(1);
          if (rem_q == LW'(1)) begin
            state_nxt = IT_IDLE;
            slot_nxt  = '0;
          end
        end
      end
      default: state_nxt = IT_IDLE;
    endcase
  end
`else
  logic unused_it;

  assign eff_cond  = cond_i;
  assign it_active = 1'b0;
  assign it_undef  = 1'b0;
  assign unused_it = ^{it_start_i, it_firstcond_i, it_len_i, it_then_i};
`endif

  assign it_active_o = it_active;

endmodule

// File: tb/tb_cond_exec_unit.sv
// tb/tb_cond_exec_unit.sv - directed self-checking bench for cond_exec_unit
module tb_cond_exec_unit;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [3:0] cond;
  logic [0:0] bank_sel;
  logic [1:0] flag_wr;
  logic [3:0] alu_flags;
  logic       it_start;
  logic [3:0] it_firstcond;
  logic [2:0] it_len;
  logic [3:0] it_then;
  logic       cond_ex;
  logic       undef;
  logic [3:0] flags;
  logic       it_active;

  int checks;
  int errors;

  cond_exec_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid_i  (instr_valid),
    .cond_i         (cond),
    .bank_sel_i     (bank_sel),
    .flag_wr_i      (flag_wr),
    .alu_flags_i    (alu_flags),
    .it_start_i     (it_start),
    .it_firstcond_i (it_firstcond),
    .it_len_i       (it_len),
    .it_then_i      (it_then),
    .cond_ex_o      (cond_ex),
    .undef_o        (undef),
    .flags_o        (flags),
    .it_active_o    (it_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs;
    instr_valid  = 1'b0;
    cond         = 4'b0000;
    bank_sel     = 1'b0;
    flag_wr      = 2'b00;
    alu_flags    = 4'b0000;
    it_start     = 1'b0;
    it_firstcond = 4'b0000;
    it_len       = 3'd0;
    it_then      = 4'b0000;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    #2;
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want %b", flags, 4'b0000); end
    checks++; if (it_active !== 1'b0) begin errors++; $display("FAIL reset_it_active got %b want %b", it_active, 1'b0); end
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL reset_cond_ex got %b want %b", cond_ex, 1'b0); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_eval_basic;
    instr_valid = 1'b1;
    cond = 4'b0000;
    #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL eq_flags0 got %b want %b", cond_ex, 1'b0); end
    cond = 4'b1110; flag_wr = 2'b11; alu_flags = 4'b0100;
    #1;
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL al_exec got %b want %b", cond_ex, 1'b1); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL no_bypass got %b want %b", flags, 4'b0000); end
    next_cycle();
    flag_wr = 2'b00; cond = 4'b0000;
    #1;
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL flags_written got %b want %b", flags, 4'b0100); end
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL eq_after_write got %b want %b", cond_ex, 1'b1); end
    next_cycle();
  endtask

  task automatic test_signed_conds;
    instr_valid = 1'b1; cond = 4'b1110; flag_wr = 2'b11; alu_flags = 4'b1000;
    next_cycle();
    flag_wr = 2'b00;
    cond = 4'b1011; #1;
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL lt got %b want %b", cond_ex, 1'b1); end
    cond = 4'b1010; #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL ge got %b want %b", cond_ex, 1'b0); end
    cond = 4'b1101; #1;
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL le got %b want %b", cond_ex, 1'b1); end
    cond = 4'b1100; #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL gt got %b want %b", cond_ex, 1'b0); end
    cond = 4'b0100; #1;
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL mi got %b want %b", cond_ex, 1'b1); end
    cond = 4'b1000; #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL hi got %b want %b", cond_ex, 1'b0); end
    checks++; if (undef !== 1'b0) begin errors++; $display("FAIL hi_undef got %b want %b", undef, 1'b0); end
    cond = 4'b1111; #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL nv_exec got %b want %b", cond_ex, 1'b0); end
    checks++; if (undef !== 1'b1) begin errors++; $display("FAIL nv_undef got %b want %b", undef, 1'b1); end
    next_cycle();
  endtask

  task automatic test_invalid;
    instr_valid = 1'b0; cond = 4'b1111; #1;
    checks++; if (undef !== 1'b0) begin errors++; $display("FAIL invalid_undef got %b want %b", undef, 1'b0); end
    cond = 4'b1110; flag_wr = 2'b11; alu_flags = 4'b0000; #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL invalid_exec got %b want %b", cond_ex, 1'b0); end
    next_cycle();
    flag_wr = 2'b00; #1;
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL invalid_no_write got %b want %b", flags, 4'b1000); end
    next_cycle();
  endtask

  task automatic test_banks;
    instr_valid = 1'b1; cond = 4'b1110; bank_sel = 1'b0; flag_wr = 2'b11; alu_flags = 4'b1111;
    next_cycle();
    bank_sel = 1'b1;
    next_cycle();
    flag_wr = 2'b10; alu_flags = 4'b0000;
    next_cycle();
    flag_wr = 2'b00; #1;
    checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL bank1_nz_cleared got %b want %b", flags, 4'b0011); end
    bank_sel = 1'b0; #1;
    checks++; if (flags !== 4'b1111) begin errors++; $display("FAIL bank0_untouched got %b want %b", flags, 4'b1111); end
    cond = 4'b0001; flag_wr = 2'b11; #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL ne_fails got %b want %b", cond_ex, 1'b0); end
    next_cycle();
    flag_wr = 2'b00; #1;
    checks++; if (flags !== 4'b1111) begin errors++; $display("FAIL failed_no_write got %b want %b", flags, 4'b1111); end
    cond = 4'b1110; flag_wr = 2'b01;
    next_cycle();
    flag_wr = 2'b00; #1;
    checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL cv_only_write got %b want %b", flags, 4'b1100); end
    next_cycle();
  endtask

  task automatic test_it_block;
    clear_inputs();
    instr_valid = 1'b1; cond = 4'b1110; flag_wr = 2'b11; alu_flags = 4'b0100;
    next_cycle();
    flag_wr = 2'b00;
`ifdef COND_IT_EN
    it_start = 1'b1; it_firstcond = 4'b0000; it_len = 3'd3; it_then = 4'b0101; #1;
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL it_setup_exec got %b want %b", cond_ex, 1'b1); end
    checks++; if (undef !== 1'b0) begin errors++; $display("FAIL it_setup_undef got %b want %b", undef, 1'b0); end
    checks++; if (it_active !== 1'b0) begin errors++; $display("FAIL it_not_yet_active got %b want %b", it_active, 1'b0); end
    next_cycle();
    it_start = 1'b0; it_firstcond = 4'b0000; it_len = 3'd0; it_then = 4'b0000; cond = 4'b1111; #1;
    checks++; if (it_active !== 1'b1) begin errors++; $display("FAIL it_active_rise got %b want %b", it_active, 1'b1); end
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL it_slot0 got %b want %b", cond_ex, 1'b1); end
    checks++; if (undef !== 1'b0) begin errors++; $display("FAIL it_slot0_undef got %b want %b", undef, 1'b0); end
    next_cycle();
    instr_valid = 1'b0; #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL it_bubble_exec got %b want %b", cond_ex, 1'b0); end
    next_cycle();
    instr_valid = 1'b1; cond = 4'b1110; #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL it_slot1 got %b want %b", cond_ex, 1'b0); end
    next_cycle();
    #1;
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL it_slot2 got %b want %b", cond_ex, 1'b1); end
    checks++; if (it_active !== 1'b1) begin errors++; $display("FAIL it_active_slot2 got %b want %b", it_active, 1'b1); end
    next_cycle();
    cond = 4'b0001; #1;
    checks++; if (it_active !== 1'b0) begin errors++; $display("FAIL it_active_fall got %b want %b", it_active, 1'b0); end
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL it_after_plain got %b want %b", cond_ex, 1'b0); end
`else
    it_start = 1'b1; it_firstcond = 4'b0001; it_len = 3'd3; it_then = 4'b0101; #1;
    checks++; if (undef !== 1'b0) begin errors++; $display("FAIL itoff_setup_undef got %b want %b", undef, 1'b0); end
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL itoff_setup_exec got %b want %b", cond_ex, 1'b1); end
    next_cycle();
    it_start = 1'b0; cond = 4'b0000; #1;
    checks++; if (it_active !== 1'b0) begin errors++; $display("FAIL itoff_active got %b want %b", it_active, 1'b0); end
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL itoff_uses_cond got %b want %b", cond_ex, 1'b1); end
    it_start = 1'b1; it_len = 3'd0; #1;
    checks++; if (undef !== 1'b0) begin errors++; $display("FAIL itoff_len0_undef got %b want %b", undef, 1'b0); end
    it_start = 1'b0; it_len = 3'd0;
`endif
    next_cycle();
  endtask

  task automatic test_it_undef;
`ifdef COND_IT_EN
    clear_inputs();
    instr_valid = 1'b1; cond = 4'b1110; it_start = 1'b1; it_firstcond = 4'b1110; it_len = 3'd0; #1;
    checks++; if (undef !== 1'b1) begin errors++; $display("FAIL it_len0_undef got %b want %b", undef, 1'b1); end
    next_cycle();
    it_len = 3'd5; #1;
    checks++; if (it_active !== 1'b0) begin errors++; $display("FAIL it_len0_no_block got %b want %b", it_active, 1'b0); end
    checks++; if (undef !== 1'b1) begin errors++; $display("FAIL it_len5_undef got %b want %b", undef, 1'b1); end
    next_cycle();
    it_len = 3'd2; it_then = 4'b0011; #1;
    checks++; if (it_active !== 1'b0) begin errors++; $display("FAIL it_len5_no_block got %b want %b", it_active, 1'b0); end
    checks++; if (undef !== 1'b0) begin errors++; $display("FAIL it_len2_ok got %b want %b", undef, 1'b0); end
    next_cycle();
    #1;
    checks++; if (undef !== 1'b1) begin errors++; $display("FAIL it_nested_undef got %b want %b", undef, 1'b1); end
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL it_nested_exec got %b want %b", cond_ex, 1'b1); end
    next_cycle();
    it_start = 1'b0; #1;
    checks++; if (it_active !== 1'b1) begin errors++; $display("FAIL it_nested_still_active got %b want %b", it_active, 1'b1); end
    next_cycle();
    #1;
    checks++; if (it_active !== 1'b0) begin errors++; $display("FAIL it_nested_consumed got %b want %b", it_active, 1'b0); end
    next_cycle();
`endif
  endtask

  task automatic test_reset_mid;
    clear_inputs();
    instr_valid = 1'b1; cond = 4'b1110; flag_wr = 2'b11; alu_flags = 4'b1010;
    next_cycle();
    flag_wr = 2'b00;
`ifdef COND_IT_EN
    it_start = 1'b1; it_firstcond = 4'b1110; it_len = 3'd3; it_then = 4'b1111;
    next_cycle();
    it_start = 1'b0;
    checks++; if (it_active !== 1'b1) begin errors++; $display("FAIL rst_mid_active_before got %b want %b", it_active, 1'b1); end
`endif
    checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL rst_mid_flags_before got %b want %b", flags, 4'b1010); end
    rst_n = 1'b0; #1;
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags got %b want %b", flags, 4'b0000); end
    checks++; if (it_active !== 1'b0) begin errors++; $display("FAIL rst_mid_active got %b want %b", it_active, 1'b0); end
    clear_inputs();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rst_release_flags got %b want %b", flags, 4'b0000); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_eval_basic();
    test_signed_conds();
    test_invalid();
    test_banks();
    test_it_block();
    test_it_undef();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
